data_memory_handler: RTL and testbench



---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_byte_sequencer.sv | 59 +++++
 rtl/data_memory_handler.sv | 104 ++++++++++
 tb/tb_data_memory_handler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-serial data memory.
package dm_pkg;

    localparam int unsigned DT_W  = 2;
    localparam int unsigned IDX_W = 3;

    localparam logic [DT_W-1:0] DT_BYTE   = 2'd0;
    localparam logic [DT_W-1:0] DT_HALF   = 2'd1;
    localparam logic [DT_W-1:0] DT_WORD   = 2'd2;
    localparam logic [DT_W-1:0] DT_DOUBLE = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } dm_state_e;

    // Byte count for a size code.
    function automatic logic [3:0] dt_bytes(input logic [DT_W-1:0] code);
        case (code)
            DT_BYTE: return 4'd1;
            DT_HALF: return 4'd2;
            DT_WORD: return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dm_byte_sequencer.sv
// Request acceptance and per-byte address/lane sequencing for one access engine.
module dm_byte_sequencer
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DT_W-1:0]   dtype,
    output logic              busy,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] byte_addr,
    output logic              accept_c,
    output logic              done_c,
    output logic              idle
);

    dm_state_e         state;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  last_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            base     <= '0;
            last_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        base     <= addr;
                        last_idx <= IDX_W'(dt_bytes(dtype) - 4'd1);
                        idx      <= '0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (idx == last_idx) begin
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address wraps naturally at ADDR_W bits.
    assign byte_addr = base + ADDR_W'(idx);
    assign busy      = (state == ST_XFER);
    assign accept_c  = (state == ST_IDLE) && req;
    assign done_c    = busy && (idx == last_idx);
    assign idle      = (state == ST_IDLE) && !req;

endmodule

// File: rtl/data_memory_handler.sv
// Byte-addressed data memory with independent byte-serial write and read engines.
module data_memory_handler
    import dm_pkg::*;
#(
    parameter int unsigned DOUBLEWORD_WIDTH = 64,
    parameter int unsigned DATA_MEMORY_SIZE = 1024,
    parameter int unsigned ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
    parameter int unsigned DATA_TYPE_WIDTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DOUBLEWORD_WIDTH-1:0] data_bus_wr,
    input  logic [ADDR_WIDTH_DM-1:0]    addr_wr,
    input  logic [DATA_TYPE_WIDTH-1:0]  data_type_wr,
    input  logic                        wr_ins,
    output logic                        wr_idle,
    input  logic [ADDR_WIDTH_DM-1:0]    addr_rd,
    input  logic [DATA_TYPE_WIDTH-1:0]  data_type_rd,
    input  logic                        rd_ins,
    output logic [DOUBLEWORD_WIDTH-1:0] data_bus_rd,
    output logic                        rd_idle
);

    logic [7:0] mem [DATA_MEMORY_SIZE];

    logic                        wr_busy, wr_accept_c, wr_done_c;
    logic [IDX_W-1:0]            wr_idx;
    logic [ADDR_WIDTH_DM-1:0]    wr_byte_addr;
    logic [DOUBLEWORD_WIDTH-1:0] wr_data_q;

    logic                        rd_busy, rd_accept_c, rd_done_c;
    logic [IDX_W-1:0]            rd_idx;
    logic [ADDR_WIDTH_DM-1:0]    rd_byte_addr;
    logic [DOUBLEWORD_WIDTH-1:0] rd_buf;
    logic [DOUBLEWORD_WIDTH-1:0] rd_merge_c;

    dm_byte_sequencer #(.ADDR_W(ADDR_WIDTH_DM)) u_wr_seq (
        .clk       (clk),
        .rst       (rst),
        .req       (wr_ins),
        .addr      (addr_wr),
        .dtype     (data_type_wr),
        .busy      (wr_busy),
        .idx       (wr_idx),
        .byte_addr (wr_byte_addr),
        .accept_c  (wr_accept_c),
        .done_c    (wr_done_c),
        .idle      (wr_idle)
    );

    dm_byte_sequencer #(.ADDR_W(ADDR_WIDTH_DM)) u_rd_seq (
        .clk       (clk),
        .rst       (rst),
        .req       (rd_ins),
        .addr      (addr_rd),
        .dtype     (data_type_rd),
        .busy      (rd_busy),
        .idx       (rd_idx),
        .byte_addr (rd_byte_addr),
        .accept_c  (rd_accept_c),
        .done_c    (rd_done_c),
        .idle      (rd_idle)
    );

    // Write payload held for the duration of the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_data_q <= '0;
        end else if (wr_accept_c) begin
            wr_data_q <= data_bus_wr;
        end
    end

    // Memory array is intentionally not reset; reset forces the writer idle.
    always_ff @(posedge clk) begin
        if (wr_busy) begin
            mem[wr_byte_addr] <= wr_data_q[{wr_idx, 3'b000} +: 8];
        end
    end

    always_comb begin
        rd_merge_c = rd_buf;
        rd_merge_c[{rd_idx, 3'b000} +: 8] = mem[rd_byte_addr];
    end

    // Reads sample the array before same-edge writes land, returning old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_buf      <= '0;
            data_bus_rd <= '0;
        end else if (rd_accept_c) begin
            rd_buf <= '0;
        end else if (rd_busy) begin
            rd_buf <= rd_merge_c;
            if (rd_done_c) begin
                data_bus_rd <= rd_merge_c;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = wr_done_c;

endmodule

// File: tb/tb_data_memory_handler.sv
// Randomized self-checking bench for data_memory_handler against a byte-array model.
module tb_data_memory_handler;

    localparam int unsigned MEM_SZ = 1024;
    localparam int unsigned AW     = 10;
    localparam int unsigned BOUND  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   data_bus_wr = '0;
    logic [AW-1:0] addr_wr = '0;
    logic [1:0]    data_type_wr = '0;
    logic          wr_ins = 1'b0;
    logic          wr_idle;
    logic [AW-1:0] addr_rd = '0;
    logic [1:0]    data_type_rd = '0;
    logic          rd_ins = 1'b0;
    logic [63:0]   data_bus_rd;
    logic          rd_idle;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] model [MEM_SZ];

    always #5 clk = ~clk;

    data_memory_handler dut (
        .clk          (clk),
        .rst          (rst),
        .data_bus_wr  (data_bus_wr),
        .addr_wr      (addr_wr),
        .data_type_wr (data_type_wr),
        .wr_ins       (wr_ins),
        .wr_idle      (wr_idle),
        .addr_rd      (addr_rd),
        .data_type_rd (data_type_rd),
        .rd_ins       (rd_ins),
        .data_bus_rd  (data_bus_rd),
        .rd_idle      (rd_idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] t);
        return 1 << t;
    endfunction

    // Little-endian value of k bytes starting at a, with address wrap.
    function automatic logic [63:0] model_read(input logic [AW-1:0] a, input logic [1:0] t);
        logic [63:0] v = '0;
        for (int i = 0; i < nbytes(t); i++)
            v[8*i +: 8] = model[(int'(a) + i) % MEM_SZ];
        return v;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [1:0] t,
                                        input logic [63:0] d, input int limit);
        for (int i = 0; i < nbytes(t) && i < limit; i++)
            model[(int'(a) + i) % MEM_SZ] = d[8*i +: 8];
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [1:0] t,
                            input logic [63:0] d, output int busy);
        @(negedge clk);
        addr_wr = a; data_type_wr = t; data_bus_wr = d; wr_ins = 1'b1;
        @(negedge clk);
        wr_ins = 1'b0;
        busy = 0;
        while (!wr_idle && busy < BOUND) begin
            busy++;
            @(negedge clk);
        end
        if (busy >= BOUND) check("wr_timeout", 64'(busy), 64'(nbytes(t)));
        model_write(a, t, d, 8);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [1:0] t,
                           output logic [63:0] q, output int busy);
        @(negedge clk);
        addr_rd = a; data_type_rd = t; rd_ins = 1'b1;
        @(negedge clk);
        rd_ins = 1'b0;
        busy = 0;
        while (!rd_idle && busy < BOUND) begin
            busy++;
            @(negedge clk);
        end
        if (busy >= BOUND) check("rd_timeout", 64'(busy), 64'(nbytes(t)));
        q = data_bus_rd;
    endtask

    // Concurrent write and read; per edge e the read samples before write byte e lands.
    task automatic do_both(input logic [AW-1:0] wa, input logic [1:0] wt, input logic [63:0] d,
                           input logic [AW-1:0] ra, input logic [1:0] rt, output logic [63:0] exp_q,
                           output logic [63:0] q);
        int cyc;
        int kmax;
        exp_q = '0;
        kmax = (nbytes(wt) > nbytes(rt)) ? nbytes(wt) : nbytes(rt);
        for (int e = 0; e < kmax; e++) begin
            if (e < nbytes(rt)) exp_q[8*e +: 8] = model[(int'(ra) + e) % MEM_SZ];
            if (e < nbytes(wt)) model[(int'(wa) + e) % MEM_SZ] = d[8*e +: 8];
        end
        @(negedge clk);
        addr_wr = wa; data_type_wr = wt; data_bus_wr = d; wr_ins = 1'b1;
        addr_rd = ra; data_type_rd = rt; rd_ins = 1'b1;
        @(negedge clk);
        wr_ins = 1'b0; rd_ins = 1'b0;
        cyc = 0;
        while (!(wr_idle && rd_idle) && cyc < BOUND) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= BOUND) check("both_timeout", 64'(cyc), 64'(kmax));
        q = data_bus_rd;
    endtask

    initial begin
        int          busy;
        logic [63:0] q, eq, d;
        logic [AW-1:0] a, ra;
        logic [1:0]  t, rt;

        repeat (3) @(negedge clk);
        check("rst_wr_idle", 64'(wr_idle), 64'd1);
        check("rst_rd_idle", 64'(rd_idle), 64'd1);
        check("rst_rd_bus", data_bus_rd, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < int'(MEM_SZ / 8); i++) begin
            d = {$urandom, $urandom};
            do_write(AW'(i * 8), 2'd3, d, busy);
        end

        @(negedge clk);
        addr_wr = AW'(10'h010); data_type_wr = 2'd3; data_bus_wr = 64'h1122334455667788; wr_ins = 1'b1;
        #1 check("wr_idle_req_cycle", 64'(wr_idle), 64'd0);
        @(negedge clk);
        wr_ins = 1'b0;
        busy = 0;
        while (!wr_idle && busy < BOUND) begin busy++; @(negedge clk); end
        model_write(AW'(10'h010), 2'd3, 64'h1122334455667788, 8);
        check("dw_write_busy", 64'(busy), 64'd8);
        do_read(AW'(10'h010), 2'd3, q, busy);
        check("dw_readback", q, 64'h1122334455667788);
        check("dw_read_busy", 64'(busy), 64'd8);
        do_read(AW'(10'h012), 2'd1, q, busy);
        check("half_read", q, 64'h0000_0000_0000_5566);
        check("half_read_busy", 64'(busy), 64'd2);
        check("half_rd_idle", 64'(rd_idle), 64'd1);

        do_write(AW'(10'h3FE), 2'd2, 64'hAABBCCDD, busy);
        do_read(AW'(10'h3FE), 2'd2, q, busy);
        check("wrap_word", q, 64'hAABBCCDD);
        do_read(AW'(10'h000), 2'd1, q, busy);
        check("wrap_low_half", q, 64'h0000_AABB);

        do_write(AW'(10'h020), 2'd0, 64'h5A, busy);
        do_both(AW'(10'h020), 2'd0, 64'hEE, AW'(10'h020), 2'd0, eq, q);
        check("same_edge_old", q, 64'h5A);
        check("same_edge_model", q, eq);
        do_read(AW'(10'h020), 2'd0, q, busy);
        check("same_edge_new", q, 64'hEE);

        // Reset three bytes into an 8-byte write.
        do_read(AW'(10'h010), 2'd3, q, busy);
        @(negedge clk);
        addr_wr = AW'(10'h100); data_type_wr = 2'd3; data_bus_wr = 64'hF0E1D2C3B4A59687; wr_ins = 1'b1;
        @(negedge clk);
        wr_ins = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_wr_idle", 64'(wr_idle), 64'd1);
        check("abort_rd_idle", 64'(rd_idle), 64'd1);
        check("abort_rd_bus", data_bus_rd, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_write(AW'(10'h100), 2'd3, 64'hF0E1D2C3B4A59687, 3);
        do_read(AW'(10'h100), 2'd3, q, busy);
        check("abort_partial", q, model_read(AW'(10'h100), 2'd3));

        // A wr_ins pulse mid-transfer must be ignored.
        @(negedge clk);
        addr_wr = AW'(10'h200); data_type_wr = 2'd3; data_bus_wr = 64'h0123456789ABCDEF; wr_ins = 1'b1;
        @(negedge clk);
        wr_ins = 1'b0;
        repeat (2) @(negedge clk);
        addr_wr = AW'(10'h300); data_type_wr = 2'd0; data_bus_wr = 64'h77; wr_ins = 1'b1;
        @(negedge clk);
        wr_ins = 1'b0;
        busy = 0;
        while (!wr_idle && busy < BOUND) begin busy++; @(negedge clk); end
        model_write(AW'(10'h200), 2'd3, 64'h0123456789ABCDEF, 8);
        check("ignore_busy", 64'(busy), 64'd5);
        do_read(AW'(10'h200), 2'd3, q, busy);
        check("ignore_inflight", q, 64'h0123456789ABCDEF);
        do_read(AW'(10'h300), 2'd0, q, busy);
        check("ignore_target", q, model_read(AW'(10'h300), 2'd0));

        for (int n = 0; n < 80; n++) begin
            a  = AW'($urandom_range(0, MEM_SZ - 1));
            ra = AW'($urandom_range(0, MEM_SZ - 1));
            t  = 2'($urandom_range(0, 3));
            rt = 2'($urandom_range(0, 3));
            d  = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: do_write(a, t, d, busy);
                1: begin
                    do_read(ra, rt, q, busy);
                    check("rand_read", q, model_read(ra, rt));
                    check("rand_read_busy", 64'(busy), 64'(nbytes(rt)));
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) ra = a + AW'($urandom_range(0, 3));
                    do_both(a, t, d, ra, rt, eq, q);
                    check("rand_both", q, eq);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
